// File: rtl/card_draw_arbiter.sv
// Round-robin card dealer over a finite shoe: samples a free-running LFSR,
// rejects ranks that are used up, and falls back to a linear scan after MAX_RETRY rejects.
module card_draw_arbiter #(
  parameter int unsigned N         = 3,
  parameter int unsigned DECKS     = 1,
  parameter int unsigned MAX_RETRY = 4,
  parameter int unsigned LOW_WATER = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shuffle,
  input  logic [N-1:0]                  req,
  input  logic [3:0]                    rnd,
  output logic [N-1:0]                  ack,
  output logic [3:0]                    card,
  output logic                          busy,
  output logic [$clog2(52*DECKS+1)-1:0] cards_left,
  output logic                          deck_low,
  output logic                          deck_empty
);

  localparam int unsigned COPIES = 4 * DECKS;
  localparam int unsigned TOTAL  = 52 * DECKS;
  localparam int unsigned CLW    = $clog2(TOTAL + 1);
  localparam int unsigned CW     = $clog2(COPIES + 1);
  localparam int unsigned GW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW     = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  typedef enum logic [2:0] {StIdle, StSample, StScan, StDeliver, StShuffle} state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [3:0]     ptr_q, ptr_d;
  logic [3:0]     card_r_q, card_r_d;
  logic           shuffle_pend_q, shuffle_pend_d;
  logic [CW-1:0]  count_q [13];
  logic [CW-1:0]  count_d [13];
  logic [CLW-1:0] cards_left_d;
  logic [N-1:0]   ack_d;
  logic [3:0]     card_d;
  logic [15:0]    avail;
  logic           found;
  logic [GW-1:0]  idx;

  // avail[r] is set for ranks 1..13 with copies left; bits 0, 14, 15 stay clear so
  // an out-of-range LFSR value is rejected by the same lookup.
  always_comb begin
    avail = '0;
    for (int r = 0; r < 13; r++) begin
      avail[r+1] = (count_q[r] < CW'(COPIES));
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    retry_d        = retry_q;
    ptr_d          = ptr_q;
    card_r_d       = card_r_q;
    count_d        = count_q;
    cards_left_d   = cards_left;
    ack_d          = '0;
    card_d         = '0;
    found          = 1'b0;
    idx            = last_grant_q;
    shuffle_pend_d = shuffle_pend_q | shuffle;

    unique case (state_q)
      StIdle: begin
        if (shuffle_pend_q) begin
          state_d = StShuffle;
        end else if (!deck_empty && |req) begin
          for (int i = 0; i < int'(N); i++) begin
            idx = (idx == GW'(N - 1)) ? '0 : idx + GW'(1);
            if (!found && req[idx]) begin
              found   = 1'b1;
              grant_d = idx;
            end
          end
          retry_d = '0;
          state_d = StSample;
        end
      end

      StSample: begin
        if (avail[rnd]) begin
          card_r_d = rnd;
          state_d  = StDeliver;
        end else if (retry_q == RW'(MAX_RETRY - 1)) begin
          ptr_d   = (rnd >= 4'd1 && rnd <= 4'd13) ? rnd : 4'd1;
          state_d = StScan;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end

      // Shoe is non-empty whenever a draw starts, so this finds a rank within 13 steps.
      StScan: begin
        if (avail[ptr_q]) begin
          card_r_d = ptr_q;
          state_d  = StDeliver;
        end else begin
          ptr_d = (ptr_q == 4'd13) ? 4'd1 : ptr_q + 4'd1;
        end
      end

      StDeliver: begin
        if (req[grant_q]) begin
          ack_d                    = N'(1) << grant_q;
          card_d                   = card_r_q;
          count_d[card_r_q - 4'd1] = count_q[card_r_q - 4'd1] + CW'(1);
          cards_left_d             = cards_left - CLW'(1);
          last_grant_d             = grant_q;
        end
        state_d = StIdle;
      end

      StShuffle: begin
        count_d        = '{default: '0};
        cards_left_d   = CLW'(TOTAL);
        shuffle_pend_d = shuffle;
        state_d        = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      grant_q        <= '0;
      last_grant_q   <= GW'(N - 1);
      retry_q        <= '0;
      ptr_q          <= 4'd1;
      card_r_q       <= '0;
      shuffle_pend_q <= 1'b0;
      count_q        <= '{default: '0};
      cards_left     <= CLW'(TOTAL);
      deck_low       <= (TOTAL <= LOW_WATER);
      deck_empty     <= 1'b0;
      ack            <= '0;
      card           <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      retry_q        <= retry_d;
      ptr_q          <= ptr_d;
      card_r_q       <= card_r_d;
      shuffle_pend_q <= shuffle_pend_d;
      count_q        <= count_d;
      cards_left     <= cards_left_d;
      deck_low       <= (32'(cards_left_d) <= LOW_WATER);
      deck_empty     <= (cards_left_d == '0);
      ack            <= ack_d;
      card           <= card_d;
      busy           <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Scoreboard bench for card_draw_arbiter: expected grants/cards are queued when a request is
// driven and popped when an ack appears; a small shoe model tracks per-rank counts.
module tb_card_draw_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       shuffle;
  logic [2:0] req;
  logic [3:0] rnd;
  logic [2:0] ack;
  logic [3:0] card;
  logic       busy;
  logic [5:0] cards_left;
  logic       deck_low;
  logic       deck_empty;

  typedef struct packed {
    logic [2:0] ack;
    logic [3:0] card;
  } exp_t;

  exp_t sb[$];
  exp_t exp_v;
  int   tests  = 0;
  int   errors = 0;
  int   mcnt[14];
  int   mleft;
  int   lat;

  card_draw_arbiter #(
    .N(3),
    .DECKS(1),
    .MAX_RETRY(4),
    .LOW_WATER(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .shuffle(shuffle),
    .req(req),
    .rnd(rnd),
    .ack(ack),
    .card(card),
    .busy(busy),
    .cards_left(cards_left),
    .deck_low(deck_low),
    .deck_empty(deck_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 14; r++) mcnt[r] = 0;
    mleft = 52;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req = '0;
    shuffle = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
  endtask

  // Waits up to max_cyc cycles for any ack; l is the cycle it appeared on, or -1.
  task automatic wait_ack(input int max_cyc, output int l);
    bit seen;
    seen = 1'b0;
    l = -1;
    for (int c = 1; c <= max_cyc && !seen; c++) begin
      tick();
      if (ack !== 3'b000) begin
        seen = 1'b1;
        l = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    shuffle = 1'b0;
    rnd = '0;
    #2;
    tick();
    tests++; if (ack !== 3'b000) begin errors++; $display("FAIL rst_ack got %b want 000", ack); end
    tests++; if (card !== 4'd0) begin errors++; $display("FAIL rst_card got %0d want 0", card); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++;
    if (cards_left !== 6'd52) begin
      errors++; $display("FAIL rst_left got %0d want 52", cards_left);
    end
    tests++; if (deck_low !== 1'b0) begin errors++; $display("FAIL rst_low got %b want 0", deck_low); end
    tests++;
    if (deck_empty !== 1'b0) begin
      errors++; $display("FAIL rst_empty got %b want 0", deck_empty);
    end
    rst = 1'b1;
    model_reset();
    tick();
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    rnd = 4'd5;
    req = 3'b001;
    sb.push_back(exp_t'{3'b001, 4'd5});
    for (int c = 1; c <= 2; c++) begin
      tick();
      tests++;
      if (busy !== 1'b1 || ack !== 3'b000) begin
        errors++; $display("FAIL single_busy c%0d got busy=%b ack=%b want 1/000", c, busy, ack);
      end
    end
    tick();
    exp_v = sb.pop_front();
    tests++;
    if (ack !== exp_v.ack || card !== exp_v.card) begin
      errors++;
      $display("FAIL single_ack got %b/%0d want %b/%0d", ack, card, exp_v.ack, exp_v.card);
    end
    tests++;
    if (cards_left !== 6'd51 || busy !== 1'b0) begin
      errors++; $display("FAIL single_left got %0d busy=%b want 51/0", cards_left, busy);
    end
    req = '0;
    tick();
    tests++; if (ack !== 3'b000) begin errors++; $display("FAIL single_width got %b want 000", ack); end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [4];
    int         cards [4];
    apply_reset();
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    cards = '{2, 3, 4, 6};
    for (int k = 0; k < 4; k++) sb.push_back(exp_t'{order[k], 4'(cards[k])});
    rnd = 4'(cards[0]);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(8, lat);
      exp_v = sb.pop_front();
      tests++;
      if (lat != ((k == 0) ? 3 : 2)) begin
        errors++; $display("FAIL rr_lat%0d got %0d want %0d", k, lat, (k == 0) ? 3 : 2);
      end
      tests++;
      if (ack !== exp_v.ack || card !== exp_v.card) begin
        errors++;
        $display("FAIL rr_ack%0d got %b/%0d want %b/%0d", k, ack, card, exp_v.ack, exp_v.card);
      end
      mcnt[cards[k]]++;
      mleft--;
      if (k < 3) rnd = 4'(cards[k+1]);
      else req = '0;
      tick();
      tests++; if (ack !== 3'b000) begin errors++; $display("FAIL rr_width%0d got %b", k, ack); end
    end
    tests++;
    if (cards_left !== 6'(mleft)) begin
      errors++; $display("FAIL rr_left got %0d want %0d", cards_left, mleft);
    end
  endtask

  task automatic test_retry_scan();
    rnd = 4'd0;
    req = 3'b100;
    sb.push_back(exp_t'{3'b100, 4'd1});
    wait_ack(12, lat);
    exp_v = sb.pop_front();
    tests++; if (lat != 7) begin errors++; $display("FAIL retry_lat got %0d want 7", lat); end
    tests++;
    if (ack !== exp_v.ack || card !== exp_v.card) begin
      errors++;
      $display("FAIL retry_ack got %b/%0d want %b/%0d", ack, card, exp_v.ack, exp_v.card);
    end
    mcnt[1]++;
    mleft--;
    req = '0;
  endtask

  task automatic test_deplete();
    int  pick;
    bit  hit;
    rnd = 4'd7;
    req = 3'b001;
    for (int k = 0; k < 5; k++) begin
      sb.push_back(exp_t'{3'b001, (k < 4) ? 4'd7 : 4'd8});
      wait_ack(12, lat);
      exp_v = sb.pop_front();
      tests++;
      if (lat != ((k < 4) ? 3 : 8)) begin
        errors++; $display("FAIL dep7_lat%0d got %0d want %0d", k, lat, (k < 4) ? 3 : 8);
      end
      tests++;
      if (ack !== exp_v.ack || card !== exp_v.card) begin
        errors++;
        $display("FAIL dep7_ack%0d got %b/%0d want %b/%0d", k, ack, card, exp_v.ack, exp_v.card);
      end
      mcnt[(k < 4) ? 7 : 8]++;
      mleft--;
    end
    while (mleft > 0) begin
      pick = 0;
      for (int r = 13; r >= 1; r--) if (mcnt[r] < 4) pick = r;
      rnd = 4'(pick);
      sb.push_back(exp_t'{3'b001, 4'(pick)});
      wait_ack(8, lat);
      exp_v = sb.pop_front();
      mcnt[pick]++;
      mleft--;
      tests++;
      if (ack !== exp_v.ack || card !== exp_v.card || lat != 3) begin
        errors++;
        $display("FAIL drain_ack left%0d got %b/%0d lat%0d want %b/%0d lat3", mleft, ack, card,
                 lat, exp_v.ack, exp_v.card);
      end
      tests++;
      if (cards_left !== 6'(mleft) || deck_low !== (mleft <= 15) || deck_empty !== (mleft == 0))
      begin
        errors++;
        $display("FAIL drain_flags got %0d/%b/%b want %0d/%b/%b", cards_left, deck_low,
                 deck_empty, mleft, mleft <= 15, mleft == 0);
      end
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      tests++;
      if (ack !== 3'b000 || busy !== 1'b0) begin
        errors++; $display("FAIL empty_noack c%0d got ack=%b busy=%b want 000/0", c, ack, busy);
      end
    end
    rnd = 4'd5;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (cards_left === 6'd52) hit = 1'b1;
      else tick();
    end
    tests++; if (!hit) begin errors++; $display("FAIL refill_left got %0d want 52", cards_left); end
    tests++;
    if (deck_empty !== 1'b0 || deck_low !== 1'b0) begin
      errors++; $display("FAIL refill_flags got %b/%b want 0/0", deck_empty, deck_low);
    end
    sb.push_back(exp_t'{3'b001, 4'd5});
    wait_ack(8, lat);
    exp_v = sb.pop_front();
    tests++;
    if (ack !== exp_v.ack || card !== exp_v.card || cards_left !== 6'd51) begin
      errors++;
      $display("FAIL refill_serve got %b/%0d left%0d want %b/%0d left51", ack, card, cards_left,
               exp_v.ack, exp_v.card);
    end
    req = '0;
    model_reset();
    mcnt[5] = 1;
    mleft = 51;
  endtask

  task automatic test_shuffle_during();
    rnd = 4'd9;
    req = 3'b001;
    sb.push_back(exp_t'{3'b001, 4'd9});
    tick();
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    tick();
    exp_v = sb.pop_front();
    tests++;
    if (ack !== exp_v.ack || card !== exp_v.card || cards_left !== 6'd50) begin
      errors++;
      $display("FAIL shdur_ack got %b/%0d left%0d want %b/%0d left50", ack, card, cards_left,
               exp_v.ack, exp_v.card);
    end
    req = '0;
    tick();
    tests++; if (busy !== 1'b1) begin errors++; $display("FAIL shdur_busy got %b want 1", busy); end
    tick();
    tests++;
    if (cards_left !== 6'd52 || busy !== 1'b0) begin
      errors++; $display("FAIL shdur_left got %0d busy=%b want 52/0", cards_left, busy);
    end
    model_reset();
  endtask

  task automatic test_drop();
    rnd = 4'd3;
    req = 3'b010;
    tick();
    req = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests++; if (ack !== 3'b000) begin errors++; $display("FAIL drop_ack c%0d got %b", c, ack); end
    end
    tests++;
    if (cards_left !== 6'(mleft)) begin
      errors++; $display("FAIL drop_left got %0d want %0d", cards_left, mleft);
    end
  endtask

  task automatic test_async_reset();
    rnd = 4'd4;
    req = 3'b001;
    sb.push_back(exp_t'{3'b001, 4'd4});
    wait_ack(8, lat);
    exp_v = sb.pop_front();
    tests++;
    if (ack !== exp_v.ack || card !== exp_v.card || cards_left !== 6'd51) begin
      errors++;
      $display("FAIL arst_pre got %b/%0d left%0d want %b/%0d left51", ack, card, cards_left,
               exp_v.ack, exp_v.card);
    end
    rnd = 4'd0;
    repeat (5) tick();
    tests++;
    if (busy !== 1'b1 || ack !== 3'b000) begin
      errors++; $display("FAIL arst_scan got busy=%b ack=%b want 1/000", busy, ack);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (ack !== 3'b000 || card !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL arst_out got ack=%b card=%0d busy=%b want 000/0/0", ack, card, busy);
    end
    tests++;
    if (cards_left !== 6'd52 || deck_low !== 1'b0 || deck_empty !== 1'b0) begin
      errors++;
      $display("FAIL arst_shoe got %0d/%b/%b want 52/0/0", cards_left, deck_low, deck_empty);
    end
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || ack !== 3'b000) begin
      errors++; $display("FAIL arst_after got busy=%b ack=%b want 0/000", busy, ack);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_retry_scan();
    test_deplete();
    test_shuffle_during();
    test_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/card_draw_arbiter.md
Name: card_draw_arbiter

Overview:
- Arbitrates a shared LFSR random source and a finite shoe of cards among N card requesters: local player hit, dealer draw, and the remote-link player.
- Guarantees no rank is dealt more than 4*DECKS times.
- Tells the game FSM when the shoe needs reshuffling.
- Sits between the LFSR instances and the blackjack game FSMs, replacing their direct sampling of raw LFSR values.

Parameters:
- N, 3: number of requesters; req[0] has first priority out of reset.
- DECKS, 1: decks in the shoe; COPIES = 4*DECKS per rank, TOTAL = 52*DECKS.
- MAX_RETRY, 4: rejected samples tolerated before falling back to a deterministic scan.
- LOW_WATER, 15: deck_low asserts when cards_left <= LOW_WATER.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  asynchronous, active-low reset.
- shuffle  in  1  single-cycle pulse: refill shoe.
- req  in  N  per-requester draw request, level, held until ack.
- rnd  in  4  free-running LFSR value.
- ack  out  N  one-hot, one-cycle pulse: card valid for that requester.
- card  out  4  drawn rank 1..13 (1=A, 11=J, 12=Q, 13=K); valid only with ack.
- busy  out  1  high in any state other than IDLE.
- cards_left  out  $clog2(TOTAL+1)  cards remaining in shoe.
- deck_low  out  1  cards_left <= LOW_WATER.
- deck_empty  out  1  cards_left == 0.

Behaviour:
- Reset (rst=0, async) values:
  - ack=0, card=0, busy=0.
  - cards_left=TOTAL, deck_low=(TOTAL<=LOW_WATER), deck_empty=0.
  - All 13 rank counters=0, last_grant=N-1, retry=0, shuffle_pend=0, state=IDLE.
- All outputs are registered.
- shuffle is latched into shuffle_pend in any state and serviced only from IDLE.
- A shuffle never corrupts a draw in flight.
- IDLE:
  - If shuffle_pend, go to SHUFFLE.
  - Else if deck_empty, stay in IDLE; requests wait with no ack.
  - Else if |req, grant g = the first set req scanning round-robin from last_grant+1 (mod N). Latch g, set retry=0, go to SAMPLE.
- SAMPLE, one cycle:
  - If rnd is in 1..13 and count[rnd] < COPIES: card_r=rnd, go to DELIVER.
  - Else if retry == MAX_RETRY-1: ptr = (rnd in 1..13 ? rnd : 1), go to SCAN.
  - Else retry++ and stay in SAMPLE.
- SCAN, one rank per cycle:
  - If count[ptr] < COPIES: card_r=ptr, go to DELIVER.
  - Else ptr = (ptr==13 ? 1 : ptr+1).
  - Terminates within 13 cycles because the shoe is not empty.
- DELIVER:
  - If req[g] is still high: ack[g]=1 and card=card_r for exactly this cycle, count[card_r]++, cards_left--, last_grant=g.
  - If req[g] has dropped: discard the card, no counter update, no ack, last_grant unchanged.
  - Either way, go to IDLE.
- SHUFFLE, one cycle: all counts=0, cards_left=TOTAL, shuffle_pend=0, go to IDLE.
- Timing and handshake:
  - Minimum latency from req high in IDLE to ack: 2 cycles (IDLE, then SAMPLE, then DELIVER).
  - At most one ack per draw. A requester holding req after ack is served again on the next round-robin turn.
  - A requester must drop req the cycle after ack to avoid a second draw.
- Simultaneous events:
  - shuffle in the same cycle as a DELIVER: the delivery completes first, then the shuffle runs next from IDLE.
  - All req bits high: grants rotate 0,1,2,0,...
- deck_low and deck_empty are recomputed from the next value of cards_left, so they are coincident with the cards_left update.

Test Plan:
- Reset, then req=3'b001 with rnd held at 5 → ack=3'b001 and card=5 exactly 2 cycles after req seen in IDLE; cards_left 52→51; busy high for 2 cycles.
- req=3'b111 held continuously with valid rnd → ack order 001,010,100,001; no ack overlap; each ack exactly 1 cycle wide.
- rnd forced to 0 (MAX_RETRY=4) → 4 SAMPLE cycles, then SCAN from ptr=1 → card=1, ack at cycle 6 after grant.
- Deplete all four 7s, then force rnd=7 → retries, then SCAN selects card=8. Draw 52 cards → deck_empty=1, deck_low=1; further req gets no ack; shuffle pulse → cards_left=52, deck_empty=0, pending req served.
- shuffle pulse during SAMPLE → current draw delivers normally, SHUFFLE follows; cards_left ends at 52 and the delivered card is not double-counted.
- req[g] dropped during SAMPLE → no ack, cards_left unchanged. Assert rst low mid-SCAN → all outputs return to reset values immediately, without waiting for a clock edge.
